// File: rtl/ace_dispatch_credit_if.sv
// Dispatch-group handshake between the dispatch logic (master) and the
// back-end credit controller (slave).
interface ace_dispatch_credit_if;
    logic       disp_valid_i;
    logic [2:0] disp_rob_num_i;
    logic [2:0] disp_rs0_num_i;
    logic [2:0] disp_rs1_num_i;
    logic [2:0] disp_ld_num_i;
    logic [2:0] disp_st_num_i;
    logic       dispatch_accept_o;
    logic       dispatch_frontend_stl_o;
    logic [5:0] dispatch_stall_cause_o;

    modport master (
        output disp_valid_i, disp_rob_num_i, disp_rs0_num_i, disp_rs1_num_i,
               disp_ld_num_i, disp_st_num_i,
        input  dispatch_accept_o, dispatch_frontend_stl_o, dispatch_stall_cause_o
    );

    modport slave (
        input  disp_valid_i, disp_rob_num_i, disp_rs0_num_i, disp_rs1_num_i,
               disp_ld_num_i, disp_st_num_i,
        output dispatch_accept_o, dispatch_frontend_stl_o, dispatch_stall_cause_o
    );
endinterface

// File: rtl/ace_dispatch_credit.sv
// Back-end occupancy/credit controller for dispatch: ROB, RS0, RS1, LDQ, STQ
// with flush recovery. Optional stall-cycle counter under ACE_DISPATCH_PERF_EN.
module ace_dispatch_credit #(
    parameter  int unsigned ROB_DEPTH      = 32,
    parameter  int unsigned RS0_DEPTH      = 16,
    parameter  int unsigned RS1_DEPTH      = 16,
    parameter  int unsigned LDQ_DEPTH      = 8,
    parameter  int unsigned STQ_DEPTH      = 8,
    parameter  int unsigned RECOVER_CYCLES = 2,
    localparam int unsigned CW_ROB = $clog2(ROB_DEPTH + 1),
    localparam int unsigned CW_RS0 = $clog2(RS0_DEPTH + 1),
    localparam int unsigned CW_RS1 = $clog2(RS1_DEPTH + 1),
    localparam int unsigned CW_LDQ = $clog2(LDQ_DEPTH + 1),
    localparam int unsigned CW_STQ = $clog2(STQ_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    ace_dispatch_credit_if.slave  disp,
    input  logic [2:0]            retire_rob_rel_i,
    input  logic [2:0]            issue_rs0_rel_i,
    input  logic [2:0]            issue_rs1_rel_i,
    input  logic [2:0]            execute_ld_rel_i,
    input  logic [2:0]            execute_st_rel_i,
    input  logic                  flush_i,
    input  logic [CW_STQ-1:0]     flush_stq_keep_i,
    output logic [CW_ROB-1:0]     rob_cnt_o,
    output logic [CW_RS0-1:0]     rs0_cnt_o,
    output logic [CW_RS1-1:0]     rs1_cnt_o,
    output logic [CW_LDQ-1:0]     ldq_cnt_o,
    output logic [CW_STQ-1:0]     stq_cnt_o,
    output logic                  credit_err_o,
    output logic [31:0]           perf_stall_cycles_o
);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [3:0]          timer_q, timer_d;
    logic [CW_ROB-1:0]   rob_cnt_q, rob_cnt_d;
    logic [CW_RS0-1:0]   rs0_cnt_q, rs0_cnt_d;
    logic [CW_RS1-1:0]   rs1_cnt_q, rs1_cnt_d;
    logic [CW_LDQ-1:0]   ldq_cnt_q, ldq_cnt_d;
    logic [CW_STQ-1:0]   stq_cnt_q, stq_cnt_d;
    logic                err_q, err_d;
    logic [5:0]          cause;
    logic                stall, accept;
    logic                ovf_rob, ovf_rs0, ovf_rs1, ovf_ldq, ovf_stq;

    // Signed update so underflow is visible before clamping into [0, depth].
    function automatic int sat_upd(input int cur, input int add, input int rel,
                                   input int depth, output logic ovf);
        int v;
        v   = cur + add - rel;
        ovf = 1'b0;
        if (v < 0) begin
            v   = 0;
            ovf = 1'b1;
        end else if (v > depth) begin
            v   = depth;
            ovf = 1'b1;
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            timer_q   <= '0;
            rob_cnt_q <= '0;
            rs0_cnt_q <= '0;
            rs1_cnt_q <= '0;
            ldq_cnt_q <= '0;
            stq_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rob_cnt_q <= rob_cnt_d;
            rs0_cnt_q <= rs0_cnt_d;
            rs1_cnt_q <= rs1_cnt_d;
            ldq_cnt_q <= ldq_cnt_d;
            stq_cnt_q <= stq_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rob_cnt_d = rob_cnt_q;
        rs0_cnt_d = rs0_cnt_q;
        rs1_cnt_d = rs1_cnt_q;
        ldq_cnt_d = ldq_cnt_q;
        stq_cnt_d = stq_cnt_q;
        err_d     = err_q;
        ovf_rob   = 1'b0;
        ovf_rs0   = 1'b0;
        ovf_rs1   = 1'b0;
        ovf_ldq   = 1'b0;
        ovf_stq   = 1'b0;
        if (flush_i) begin
            state_d   = RECOVER;
            timer_d   = 4'(RECOVER_CYCLES);
            rob_cnt_d = '0;
            rs0_cnt_d = '0;
            rs1_cnt_d = '0;
            ldq_cnt_d = '0;
            if (int'(flush_stq_keep_i) > int'(STQ_DEPTH)) begin
                stq_cnt_d = CW_STQ'(STQ_DEPTH);
                err_d     = 1'b1;
            end else begin
                stq_cnt_d = flush_stq_keep_i;
            end
        end else begin
            if (state_q == RECOVER) begin
                timer_d = timer_q - 4'd1;
                if (timer_q == 4'd1) state_d = RUN;
            end
            rob_cnt_d = CW_ROB'(sat_upd(int'(rob_cnt_q), accept ? int'(disp.disp_rob_num_i) : 0,
                                        int'(retire_rob_rel_i), int'(ROB_DEPTH), ovf_rob));
            rs0_cnt_d = CW_RS0'(sat_upd(int'(rs0_cnt_q), accept ? int'(disp.disp_rs0_num_i) : 0,
                                        int'(issue_rs0_rel_i), int'(RS0_DEPTH), ovf_rs0));
            rs1_cnt_d = CW_RS1'(sat_upd(int'(rs1_cnt_q), accept ? int'(disp.disp_rs1_num_i) : 0,
                                        int'(issue_rs1_rel_i), int'(RS1_DEPTH), ovf_rs1));
            ldq_cnt_d = CW_LDQ'(sat_upd(int'(ldq_cnt_q), accept ? int'(disp.disp_ld_num_i) : 0,
                                        int'(execute_ld_rel_i), int'(LDQ_DEPTH), ovf_ldq));
            stq_cnt_d = CW_STQ'(sat_upd(int'(stq_cnt_q), accept ? int'(disp.disp_st_num_i) : 0,
                                        int'(execute_st_rel_i), int'(STQ_DEPTH), ovf_stq));
            err_d = err_q | ovf_rob | ovf_rs0 | ovf_rs1 | ovf_ldq | ovf_stq;
        end
    end

    // Fit uses pre-update counts, so a same-cycle release never helps a group in.
    always_comb begin
        cause    = '0;
        cause[0] = disp.disp_valid_i &
                   (int'(ldq_cnt_q) + int'(disp.disp_ld_num_i) > int'(LDQ_DEPTH));
        cause[1] = disp.disp_valid_i &
                   (int'(stq_cnt_q) + int'(disp.disp_st_num_i) > int'(STQ_DEPTH));
        cause[2] = disp.disp_valid_i &
                   (int'(rs0_cnt_q) + int'(disp.disp_rs0_num_i) > int'(RS0_DEPTH));
        cause[3] = disp.disp_valid_i &
                   (int'(rs1_cnt_q) + int'(disp.disp_rs1_num_i) > int'(RS1_DEPTH));
        cause[4] = disp.disp_valid_i &
                   (int'(rob_cnt_q) + int'(disp.disp_rob_num_i) > int'(ROB_DEPTH));
        cause[5] = (state_q == RECOVER) | flush_i;
        stall    = |cause;
        accept   = disp.disp_valid_i & ~stall;
        disp.dispatch_stall_cause_o  = cause;
        disp.dispatch_frontend_stl_o = stall;
        disp.dispatch_accept_o       = accept;
    end

    assign rob_cnt_o    = rob_cnt_q;
    assign rs0_cnt_o    = rs0_cnt_q;
    assign rs1_cnt_o    = rs1_cnt_q;
    assign ldq_cnt_o    = ldq_cnt_q;
    assign stq_cnt_o    = stq_cnt_q;
    assign credit_err_o = err_q;

`ifdef ACE_DISPATCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (disp.disp_valid_i && stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_stall_cycles_o = perf_q;
`else
    assign perf_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ace_dispatch_credit.sv
// Self-checking bench for ace_dispatch_credit: directed scenarios plus
// randomized traffic compared every cycle against an occupancy model.
module tb_ace_dispatch_credit;

    localparam int RC = 2;
`ifdef ACE_DISPATCH_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  retire_rob_rel_i, issue_rs0_rel_i, issue_rs1_rel_i;
    logic [2:0]  execute_ld_rel_i, execute_st_rel_i;
    logic        flush_i;
    logic [3:0]  flush_stq_keep_i;
    logic [5:0]  rob_cnt_o;
    logic [4:0]  rs0_cnt_o, rs1_cnt_o;
    logic [3:0]  ldq_cnt_o, stq_cnt_o;
    logic        credit_err_o;
    logic [31:0] perf_stall_cycles_o;

    ace_dispatch_credit_if dif();

    ace_dispatch_credit #(
        .ROB_DEPTH(32), .RS0_DEPTH(16), .RS1_DEPTH(16),
        .LDQ_DEPTH(8), .STQ_DEPTH(8), .RECOVER_CYCLES(RC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .disp                (dif.slave),
        .retire_rob_rel_i    (retire_rob_rel_i),
        .issue_rs0_rel_i     (issue_rs0_rel_i),
        .issue_rs1_rel_i     (issue_rs1_rel_i),
        .execute_ld_rel_i    (execute_ld_rel_i),
        .execute_st_rel_i    (execute_st_rel_i),
        .flush_i             (flush_i),
        .flush_stq_keep_i    (flush_stq_keep_i),
        .rob_cnt_o           (rob_cnt_o),
        .rs0_cnt_o           (rs0_cnt_o),
        .rs1_cnt_o           (rs1_cnt_o),
        .ldq_cnt_o           (ldq_cnt_o),
        .stq_cnt_o           (stq_cnt_o),
        .credit_err_o        (credit_err_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
    );

    always #5 clk = ~clk;

    // Resource index order: 0 ld, 1 st, 2 rs0, 3 rs1, 4 rob (matches cause bits).
    int     num[5], rel[5];
    logic   val, fl;
    int     keep;
    int     mcnt[5];
    int     mrec;
    logic   merr;
    longint mperf;
    int     errors = 0, checks = 0;

    function automatic int depth(input int i);
        case (i)
            0, 1:    return 8;
            2, 3:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0:       return int'(ldq_cnt_o);
            1:       return int'(stq_cnt_o);
            2:       return int'(rs0_cnt_o);
            3:       return int'(rs1_cnt_o);
            default: return int'(rob_cnt_o);
        endcase
    endfunction

    function automatic logic [5:0] mcause();
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) c[i] = val && (mcnt[i] + num[i] > depth(i));
        c[5] = (mrec > 0) || fl;
        return c;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        val = 1'b0; fl = 1'b0; keep = 0;
        for (int i = 0; i < 5; i++) begin num[i] = 0; rel[i] = 0; end
    endtask

    task automatic group(input int ld, input int st, input int r0, input int r1, input int rob);
        idle();
        val = 1'b1;
        num[0] = ld; num[1] = st; num[2] = r0; num[3] = r1; num[4] = rob;
    endtask

    task automatic apply();
        dif.disp_valid_i   = val;
        dif.disp_ld_num_i  = 3'(num[0]);
        dif.disp_st_num_i  = 3'(num[1]);
        dif.disp_rs0_num_i = 3'(num[2]);
        dif.disp_rs1_num_i = 3'(num[3]);
        dif.disp_rob_num_i = 3'(num[4]);
        execute_ld_rel_i   = 3'(rel[0]);
        execute_st_rel_i   = 3'(rel[1]);
        issue_rs0_rel_i    = 3'(rel[2]);
        issue_rs1_rel_i    = 3'(rel[3]);
        retire_rob_rel_i   = 3'(rel[4]);
        flush_i            = fl;
        flush_stq_keep_i   = 4'(keep);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        mrec = 0; merr = 1'b0; mperf = 0;
    endtask

    task automatic model_update();
        logic [5:0] c;
        logic       acc;
        int         v;
        c   = mcause();
        acc = val && (c == 6'd0);
        if (PERF_ON != 0 && val && c != 6'd0 && mperf < 64'hFFFF_FFFF) mperf++;
        if (fl) begin
            for (int i = 0; i < 5; i++) mcnt[i] = 0;
            mcnt[1] = (keep > 8) ? 8 : keep;
            if (keep > 8) merr = 1'b1;
            mrec = RC;
        end else begin
            for (int i = 0; i < 5; i++) begin
                v = mcnt[i] + (acc ? num[i] : 0) - rel[i];
                if (v < 0)             begin v = 0;        merr = 1'b1; end
                else if (v > depth(i)) begin v = depth(i); merr = 1'b1; end
                mcnt[i] = v;
            end
            if (mrec > 0) mrec--;
        end
    endtask

    task automatic cyc_begin();
        logic [5:0] c;
        apply();
        #1;
        c = mcause();
        chk("cause",  dif.dispatch_stall_cause_o, c);
        chk("stall",  dif.dispatch_frontend_stl_o, c != 6'd0);
        chk("accept", dif.dispatch_accept_o, val && (c == 6'd0));
        for (int i = 0; i < 5; i++) chk($sformatf("cnt%0d", i), dut_cnt(i), mcnt[i]);
        chk("err",  credit_err_o, merr);
        chk("perf", perf_stall_cycles_o, mperf);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset();
        idle();
        apply();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_rob", rob_cnt_o, 0);
        chk("rst_stq", stq_cnt_o, 0);
        chk("rst_err", credit_err_o, 0);
        chk("rst_stall", dif.dispatch_frontend_stl_o, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc_exp[5];
        int fl_seq[5];
        int lim;
        idle();
        apply();
        @(negedge clk);
        do_reset();

        // Eight full-width groups fill every resource exactly.
        for (int g = 0; g < 8; g++) begin
            group(1, 1, 2, 2, 4);
            step();
        end
        chk("lit_rob32", rob_cnt_o, 32);
        chk("lit_model_rob32", mcnt[4], 32);
        // ROB-only group now stalls; four more repeats give five stalled cycles.
        group(0, 0, 0, 0, 4);
        cyc_begin();
        chk("lit_cause_rob", dif.dispatch_stall_cause_o, 6'b010000);
        chk("lit_acc_rob", dif.dispatch_accept_o, 0);
        cyc_end();
        for (int k = 0; k < 4; k++) step();
        chk("lit_perf5", perf_stall_cycles_o, PERF_ON != 0 ? 5 : 0);

        // Load queue at 7, needs 2, frees 1 in the same cycle.
        do_reset();
        group(4, 0, 0, 0, 0); step();
        group(3, 0, 0, 0, 0); step();
        chk("lit_ldq7", ldq_cnt_o, 7);
        group(2, 0, 0, 0, 0); rel[0] = 1;
        cyc_begin();
        chk("lit_ld_cause", dif.dispatch_stall_cause_o, 6'b000001);
        chk("lit_ld_acc0", dif.dispatch_accept_o, 0);
        cyc_end();
        chk("lit_ldq6", ldq_cnt_o, 6);
        group(2, 0, 0, 0, 0); rel[0] = 1;
        cyc_begin();
        chk("lit_ld_acc1", dif.dispatch_accept_o, 1);
        cyc_end();
        chk("lit_ldq7b", ldq_cnt_o, 7);

        // Single flush with stq=5 and keep=3.
        do_reset();
        group(0, 4, 0, 0, 0); step();
        group(0, 1, 0, 0, 1); step();
        chk("lit_stq5", stq_cnt_o, 5);
        acc_exp = '{0, 0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            group(0, 0, 0, 0, 1);
            if (k == 0) begin fl = 1'b1; keep = 3; end
            cyc_begin();
            chk($sformatf("lit_flush1_acc%0d", k), dif.dispatch_accept_o, acc_exp[k]);
            cyc_end();
            if (k == 0) begin
                chk("lit_flush_stq3", stq_cnt_o, 3);
                chk("lit_flush_rob0", rob_cnt_o, 0);
            end
        end

        // Second flush one cycle into recovery extends the stall.
        acc_exp = '{0, 0, 0, 0, 1};
        fl_seq  = '{1, 1, 0, 0, 0};
        for (int k = 0; k < 5; k++) begin
            group(0, 0, 0, 0, 1);
            fl = fl_seq[k] != 0;
            cyc_begin();
            chk($sformatf("lit_flush2_acc%0d", k), dif.dispatch_accept_o, acc_exp[k]);
            cyc_end();
        end

        // ROB underflow sets the sticky error.
        do_reset();
        group(0, 0, 0, 0, 2); step();
        idle(); rel[4] = 4; step();
        chk("lit_under_rob0", rob_cnt_o, 0);
        chk("lit_under_err", credit_err_o, 1);
        for (int k = 0; k < 3; k++) begin idle(); step(); end
        chk("lit_err_sticky", credit_err_o, 1);

        // Asynchronous reset in the middle of recovery.
        group(0, 1, 0, 0, 1); step();
        idle(); fl = 1'b1; keep = 2; step();
        group(0, 0, 0, 0, 1);
        apply();
        #1;
        chk("lit_rec_stall", dif.dispatch_frontend_stl_o, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("lit_arst_stall", dif.dispatch_frontend_stl_o, 0);
        chk("lit_arst_acc", dif.dispatch_accept_o, 1);
        chk("lit_arst_stq", stq_cnt_o, 0);
        chk("lit_arst_err", credit_err_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            idle();
            val = $urandom_range(0, 9) < 7;
            for (int i = 0; i < 5; i++) begin
                num[i] = $urandom_range(0, 4);
                lim = (mcnt[i] < 4) ? mcnt[i] : 4;
                if ($urandom_range(0, 63) == 0)     rel[i] = $urandom_range(0, 4);
                else if ($urandom_range(0, 1) == 0) rel[i] = 0;
                else                                rel[i] = $urandom_range(0, lim);
            end
            fl = $urandom_range(0, 24) == 0;
            keep = ($urandom_range(0, 15) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached actual=running expected=finished");
        $fatal(1);
    end

endmodule
